// File: rtl/sync_fifo_pf.sv
// -----------------------------------------------------------------------------
// sync_fifo_pf
//
// Single-clock FIFO. It offers a selectable read mode, an occupancy count,
// runtime-programmable almost-full and almost-empty thresholds, and optional
// sticky overflow/underflow error flags. Producer and consumer share i_clk,
// so no pointer synchronisation is needed.
//
// Parameters
//   DATA_WIDTH : word width in bits
//   ADDR_WIDTH : depth = 2**ADDR_WIDTH words
//   FIFO_MODE  : "STD_FIFO" (registered read, one-cycle o_rvalid pulse) or
//                "FWFT" (head word always presented on o_rdata).
//                Any other value stops elaboration.
//
// Optional feature
//   SYNC_FIFO_PF_ERR_FLAGS_EN : when defined, the sticky o_overflow and
//   o_underflow flags and their i_clr_err clear are built. When it is not
//   defined, both flags are tied low and i_clr_err is ignored.
//
// Ports
//   i_clk        : clock, all state changes on the rising edge
//   i_arstn      : asynchronous active-low reset (released synchronously)
//   i_we/i_wdata : write request and data
//   i_re         : read request (STD) / pop acknowledge (FWFT)
//   i_afull_th   : almost-full threshold,  o_afull  = count >= i_afull_th
//   i_aempty_th  : almost-empty threshold, o_aempty = count <= i_aempty_th
//   i_clr_err    : clears the sticky error flags on the next edge
//   o_full       : count == 2**ADDR_WIDTH
//   o_empty      : no readable word
//   o_count      : occupancy 0..2**ADDR_WIDTH (FWFT includes output register)
//   o_rdata      : read data
//   o_rvalid     : STD: one-cycle pulse after an accepted read; FWFT: ~o_empty
//   o_overflow   : sticky, write attempted while full
//   o_underflow  : sticky, read attempted while empty
//
// Handshake: a write is taken on a rising edge when i_we is high and o_full
// is low. A read/pop is taken when i_re is high and o_empty is low. o_full
// and o_empty act as the ready indications and come from registered state
// only. A request made against the wrong flag is dropped and, with error
// flags enabled, recorded. A write while full is rejected even if a read is
// taken on the same edge. A read while empty is rejected even if a write is
// taken on the same edge.
// -----------------------------------------------------------------------------
module sync_fifo_pf #(
  parameter int    DATA_WIDTH = 8,
  parameter int    ADDR_WIDTH = 8,
  parameter string FIFO_MODE  = "STD_FIFO"
) (
  input  logic                  i_clk,
  input  logic                  i_arstn,
  input  logic                  i_we,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH:0]   i_afull_th,
  input  logic [ADDR_WIDTH:0]   i_aempty_th,
  input  logic                  i_clr_err,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_afull,
  output logic                  o_aempty,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_rvalid,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  localparam int                  DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  // Storage. It is not reset: after a reset the pointers and count say that
  // nothing is stored, so the old contents can never be read.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  full;
  logic                  empty;  // driven by the mode-specific block below
  logic                  wr_ok;
  logic                  rd_ok;

  assign full  = (count_q == CNT_FULL);
  assign wr_ok = i_we & ~full;
  assign rd_ok = i_re & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
  end

  // The count follows accepted operations only. Rejected requests cannot
  // move it past 0 or past full.
  always_comb begin
    count_d = count_q;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= i_wdata;
    end
  end

  generate
    if (FIFO_MODE == "STD_FIFO") begin : g_std
      logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
      logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
      logic                  rvalid_q, rvalid_d;

      assign empty = (count_q == '0);

      // Registered read. o_rdata keeps the last word read until the next
      // accepted read. A read never hits the word being written on the same
      // edge: they could only share an address when the FIFO is full, and
      // then the write is rejected.
      always_comb begin
        rd_ptr_d = rd_ptr_q;
        rdata_d  = rdata_q;
        rvalid_d = rd_ok;
        if (rd_ok) begin
          rd_ptr_d = rd_ptr_q + PTR_ONE;
          rdata_d  = mem_q[rd_ptr_q];
        end
      end

      always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
          rd_ptr_q <= '0;
          rdata_q  <= '0;
          rvalid_q <= 1'b0;
        end else begin
          rd_ptr_q <= rd_ptr_d;
          rdata_q  <= rdata_d;
          rvalid_q <= rvalid_d;
        end
      end

      assign o_rdata  = rdata_q;
      assign o_rvalid = rvalid_q;
    end else if (FIFO_MODE == "FWFT") begin : g_fwft
      logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
      logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
      logic                  out_valid_q, out_valid_d;
      logic [ADDR_WIDTH:0]   ram_count;
      logic                  load;

      assign empty = ~out_valid_q;

      // count_q includes the output register. The rest of the words are
      // still in the RAM.
      assign ram_count = count_q - {{ADDR_WIDTH{1'b0}}, out_valid_q};

      // Refill the output register when it is free, or when it is being
      // popped on this edge. The pop-and-refill case keeps back-to-back
      // pops free of bubbles. A word written on this edge is not counted in
      // ram_count yet, so it reaches the output register one edge later.
      assign load = (ram_count != '0) && (!out_valid_q || rd_ok);

      always_comb begin
        rd_ptr_d    = rd_ptr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (load) begin
          rd_ptr_d    = rd_ptr_q + PTR_ONE;
          out_data_d  = mem_q[rd_ptr_q];
          out_valid_d = 1'b1;
        end else if (rd_ok) begin
          out_valid_d = 1'b0;
        end
      end

      always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
          rd_ptr_q    <= '0;
          out_data_q  <= '0;
          out_valid_q <= 1'b0;
        end else begin
          rd_ptr_q    <= rd_ptr_d;
          out_data_q  <= out_data_d;
          out_valid_q <= out_valid_d;
        end
      end

      assign o_rdata  = out_data_q;
      assign o_rvalid = out_valid_q;
    end else begin : g_bad_mode
      $error("sync_fifo_pf: FIFO_MODE must be \"STD_FIFO\" or \"FWFT\"");
    end
  endgenerate

  assign o_full   = full;
  assign o_empty  = empty;
  assign o_count  = count_q;
  // A threshold of 0 keeps o_afull high. A threshold >= depth keeps
  // o_aempty high. Both come straight from the compares.
  assign o_afull  = (count_q >= i_afull_th);
  assign o_aempty = (count_q <= i_aempty_th);

`ifdef SYNC_FIFO_PF_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // The clear is applied first, so an error on the same edge takes priority.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (i_clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (i_we && full) begin
      overflow_d = 1'b1;
    end
    if (i_re && empty) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign o_overflow  = overflow_q;
  assign o_underflow = underflow_q;
`else
  logic unused_clr_err;
  assign unused_clr_err = i_clr_err;
  assign o_overflow     = 1'b0;
  assign o_underflow    = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_pf.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_pf
//
// Runs one STD_FIFO and one FWFT instance of sync_fifo_pf (depth 16, 8-bit
// words) side by side on the same stimulus. A queue-based model of each
// FIFO predicts every output. A compare process checks both instances on
// every falling edge. Directed scenarios add hand-computed literal
// expectations. A randomized phase follows them.
// -----------------------------------------------------------------------------
module tb_sync_fifo_pf;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

`ifdef SYNC_FIFO_PF_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  // ---------------------------------------------------------------- clock/reset
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          we        = 1'b0;
  logic          re        = 1'b0;
  logic          clr       = 1'b0;
  logic [DW-1:0] wdata     = '0;
  logic [AW:0]   afull_th  = 5'd12;
  logic [AW:0]   aempty_th = 5'd3;

  logic          s_full, s_empty, s_afull, s_aempty, s_rvalid, s_ovf, s_unf;
  logic [AW:0]   s_count;
  logic [DW-1:0] s_rdata;
  logic          f_full, f_empty, f_afull, f_aempty, f_rvalid, f_ovf, f_unf;
  logic [AW:0]   f_count;
  logic [DW-1:0] f_rdata;

  sync_fifo_pf #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_MODE("STD_FIFO")) dut_std (
    .i_clk(clk), .i_arstn(rst_n), .i_we(we), .i_wdata(wdata), .i_re(re),
    .i_afull_th(afull_th), .i_aempty_th(aempty_th), .i_clr_err(clr),
    .o_full(s_full), .o_empty(s_empty), .o_afull(s_afull), .o_aempty(s_aempty),
    .o_count(s_count), .o_rdata(s_rdata), .o_rvalid(s_rvalid),
    .o_overflow(s_ovf), .o_underflow(s_unf)
  );

  sync_fifo_pf #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_MODE("FWFT")) dut_fwft (
    .i_clk(clk), .i_arstn(rst_n), .i_we(we), .i_wdata(wdata), .i_re(re),
    .i_afull_th(afull_th), .i_aempty_th(aempty_th), .i_clr_err(clr),
    .o_full(f_full), .o_empty(f_empty), .o_afull(f_afull), .o_aempty(f_aempty),
    .o_count(f_count), .o_rdata(f_rdata), .o_rvalid(f_rvalid),
    .o_overflow(f_ovf), .o_underflow(f_unf)
  );

  // ---------------------------------------------------------------- scoreboard
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the STD FIFO is a plain word queue. The FWFT FIFO is a
  // word queue plus the edge on which each word was written. A word becomes
  // visible at the head one edge after it was written.
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] fwft_q[$];
  int            fwft_t[$];
  int            edge_n = 0;
  logic [DW-1:0] m_s_rdata = '0;
  logic          m_s_rvalid = 1'b0;
  logic          m_s_ovf = 1'b0, m_s_unf = 1'b0, m_f_ovf = 1'b0, m_f_unf = 1'b0;

  function automatic bit f_visible();
    if (fwft_q.size() == 0) return 1'b0;
    return (fwft_t[0] < edge_n);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit s_w, s_r, f_w, f_r, f_vis;
    if (!rst_n) begin
      exp_q.delete();
      fwft_q.delete();
      fwft_t.delete();
      m_s_rdata  = '0;
      m_s_rvalid = 1'b0;
      m_s_ovf = 1'b0; m_s_unf = 1'b0; m_f_ovf = 1'b0; m_f_unf = 1'b0;
    end else begin
      s_w   = we && (exp_q.size() < DEPTH);
      s_r   = re && (exp_q.size() > 0);
      f_vis = f_visible();
      f_w   = we && (fwft_q.size() < DEPTH);
      f_r   = re && f_vis;
      m_s_ovf = (we && !s_w) || (m_s_ovf && !clr);
      m_s_unf = (re && !s_r) || (m_s_unf && !clr);
      m_f_ovf = (we && !f_w) || (m_f_ovf && !clr);
      m_f_unf = (re && !f_r) || (m_f_unf && !clr);
      m_s_rvalid = s_r;
      if (s_r) m_s_rdata = exp_q.pop_front();
      if (s_w) exp_q.push_back(wdata);
      edge_n++;
      if (f_r) begin
        void'(fwft_q.pop_front());
        void'(fwft_t.pop_front());
      end
      if (f_w) begin
        fwft_q.push_back(wdata);
        fwft_t.push_back(edge_n);
      end
    end
  end

  // Compare process: on every falling edge, check both DUTs against the model.
  logic chk_on = 1'b0;
  always @(negedge clk) begin
    if (chk_on) begin
      chk("std_count",  s_count,  exp_q.size());
      chk("std_full",   s_full,   exp_q.size() == DEPTH);
      chk("std_empty",  s_empty,  exp_q.size() == 0);
      chk("std_afull",  s_afull,  exp_q.size() >= int'(afull_th));
      chk("std_aempty", s_aempty, exp_q.size() <= int'(aempty_th));
      chk("std_rvalid", s_rvalid, m_s_rvalid);
      chk("std_rdata",  s_rdata,  m_s_rdata);
      chk("std_ovf",    s_ovf,    ERR_EN & m_s_ovf);
      chk("std_unf",    s_unf,    ERR_EN & m_s_unf);
      chk("fwft_count",  f_count,  fwft_q.size());
      chk("fwft_full",   f_full,   fwft_q.size() == DEPTH);
      chk("fwft_empty",  f_empty,  !f_visible());
      chk("fwft_rvalid", f_rvalid, f_visible());
      chk("fwft_afull",  f_afull,  fwft_q.size() >= int'(afull_th));
      chk("fwft_aempty", f_aempty, fwft_q.size() <= int'(aempty_th));
      chk("fwft_ovf",    f_ovf,    ERR_EN & m_f_ovf);
      chk("fwft_unf",    f_unf,    ERR_EN & m_f_unf);
      if (f_visible()) chk("fwft_rdata", f_rdata, fwft_q[0]);
    end
  end

  // ---------------------------------------------------------------- driver
  task automatic drive(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
    we = w; wdata = d; re = r; clr = c;
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int wr_pct, rd_pct;
    logic w, r, c;

    #2;
    rst_n  = 1'b0;
    chk_on = 1'b1;
    #1;
    chk("rst_s_count", s_count, 0);
    chk("rst_s_empty", s_empty, 1);
    chk("rst_s_full", s_full, 0);
    chk("rst_s_aempty", s_aempty, 1);
    chk("rst_s_afull", s_afull, 0);
    chk("rst_s_rvalid", s_rvalid, 0);
    chk("rst_f_empty", f_empty, 1);
    chk("rst_f_count", f_count, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill 0x01..0x10, checking the threshold crossings on the way.
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b0);
      if (i == 3)  chk("s5_aempty_at3", s_aempty, 1);
      if (i == 4)  chk("s5_aempty_at4", s_aempty, 0);
      if (i == 11) chk("s5_afull_at11", s_afull, 0);
      if (i == 12) chk("s5_afull_at12", s_afull, 1);
    end
    chk("s1_s_full", s_full, 1);
    chk("s1_s_count", s_count, 16);
    chk("s1_f_full", f_full, 1);
    chk("s1_f_count", f_count, 16);
    drive(1'b1, 8'h77, 1'b0, 1'b0);
    chk("s1_s_ovf", s_ovf, ERR_EN);
    chk("s1_f_ovf", f_ovf, ERR_EN);
    chk("s1_s_count_hold", s_count, 16);
    aempty_th = 5'd16;
    #1;
    chk("th_aempty_max", s_aempty, 1);
    aempty_th = 5'd3;
    #1;
    chk("th_aempty_back", s_aempty, 0);

    // Clear, then an overflow on the same edge as the clear, then clear.
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_ovf", s_ovf, 0);
    drive(1'b1, 8'h78, 1'b0, 1'b1);
    chk("clr_vs_new_ovf", s_ovf, ERR_EN);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_ovf_again", f_ovf, 0);

    // Drain 16 back-to-back.
    for (int i = 1; i <= 16; i++) begin
      chk("s2_f_head", f_rdata, i);
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      chk("s2_s_rdata", s_rdata, i);
      chk("s2_s_rvalid", s_rvalid, 1);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("s2_s_rvalid_low", s_rvalid, 0);
    chk("s2_s_empty", s_empty, 1);
    chk("s2_f_empty", f_empty, 1);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    chk("s2_s_unf", s_unf, ERR_EN);
    chk("s2_f_unf", f_unf, ERR_EN);
    chk("s2_s_rdata_hold", s_rdata, 8'h10);

    // Reset during a write burst at count 7. The underflow flag is still set.
    for (int i = 0; i < 7; i++) drive(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    chk("s6_count_pre", s_count, 7);
    we = 1'b1; wdata = 8'h99;
    afull_th = 5'd0;
    rst_n = 1'b0;
    #1;
    chk("s6_s_count", s_count, 0);
    chk("s6_s_empty", s_empty, 1);
    chk("s6_s_aempty", s_aempty, 1);
    chk("s6_s_afull_th0", s_afull, 1);
    chk("s6_s_rdata", s_rdata, 0);
    chk("s6_s_unf", s_unf, 0);
    chk("s6_f_count", f_count, 0);
    chk("s6_f_empty", f_empty, 1);
    chk("s6_f_rdata", f_rdata, 0);
    chk("s6_f_unf", f_unf, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1; we = 1'b0; afull_th = 5'd12;
    @(posedge clk);
    #1;

    // FWFT single word 0xA5.
    drive(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("s3_f_count", f_count, 1);
    chk("s3_f_empty_still", f_empty, 1);
    chk("s3_s_empty", s_empty, 0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("s3_f_empty_fall", f_empty, 0);
    chk("s3_f_rdata", f_rdata, 8'hA5);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    chk("s3_f_empty_after_pop", f_empty, 1);
    chk("s3_f_count_after_pop", f_count, 0);
    chk("s3_s_rdata", s_rdata, 8'hA5);

    // Fill to 8, then 40 cycles of simultaneous write/read across the wrap.
    for (int k = 0; k < 8; k++) drive(1'b1, 8'(k), 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    for (int j = 0; j < 40; j++) begin
      drive(1'b1, 8'(j + 8), 1'b1, 1'b0);
      chk("s4_s_count", s_count, 8);
      chk("s4_f_count", f_count, 8);
      chk("s4_s_rdata", s_rdata, j);
      chk("s4_f_head", f_rdata, j + 1);
    end

    // Threshold change at count 10 takes effect without a clock edge.
    drive(1'b1, 8'hC0, 1'b0, 1'b0);
    drive(1'b1, 8'hC1, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("s5_count10", s_count, 10);
    chk("s5_afull_th12", s_afull, 0);
    afull_th = 5'd8;
    #1;
    chk("s5_s_afull_th8", s_afull, 1);
    chk("s5_f_afull_th8", f_afull, 1);
    afull_th = 5'd12;

    // Randomized phase with biased fill/drain periods.
    wr_pct = 50; rd_pct = 50;
    for (int n = 0; n < 1500; n++) begin
      if (n % 250 == 0) begin
        case ((n / 250) % 3)
          0:       begin wr_pct = 80; rd_pct = 30; end
          1:       begin wr_pct = 30; rd_pct = 80; end
          default: begin wr_pct = 60; rd_pct = 60; end
        endcase
      end
      if ($urandom_range(0, 49) == 0) begin
        afull_th  = 5'($urandom_range(0, 16));
        aempty_th = 5'($urandom_range(0, 16));
      end
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
      end
      w = ($urandom_range(0, 99) < wr_pct);
      r = ($urandom_range(0, 99) < rd_pct);
      c = ($urandom_range(0, 19) == 0);
      drive(w, 8'($urandom_range(0, 255)), r, c);
    end

    drive(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_pf.md
# sync_fifo_pf

Single-clock FIFO with selectable standard or first-word-fall-through read mode, occupancy count, runtime-programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags. It is the single-clock, parametrised successor to the dual-clock FIFO wrapper. It is used where producer and consumer share one clock, for example stream buffering inside a datapath, so no pointer synchronisation is needed.

## Interface
- DATA_WIDTH, 8, word width in bits.
- ADDR_WIDTH, 8, depth = 2^ADDR_WIDTH words.
- FIFO_MODE, "STD_FIFO", "STD_FIFO" or "FWFT"; any other value is a synthesis error.

Ports:
- i_clk  in  1  single clock, all logic on rising edge.
- i_arstn  in  1  asynchronous active-low reset (asserted asynchronously, released synchronously to i_clk externally).
- i_we  in  1  write request.
- i_wdata  in  DATA_WIDTH  write data.
- i_re  in  1  read request (STD) / pop acknowledge (FWFT).
- i_afull_th  in  ADDR_WIDTH+1  almost-full threshold.
- i_aempty_th  in  ADDR_WIDTH+1  almost-empty threshold.
- i_clr_err  in  1  clears sticky error flags.
- o_full  out  1  count == 2^ADDR_WIDTH.
- o_empty  out  1  no readable word.
- o_afull  out  1  count >= i_afull_th.
- o_aempty  out  1  count <= i_aempty_th.
- o_count  out  ADDR_WIDTH+1  occupancy, 0..2^ADDR_WIDTH.
- o_rdata  out  DATA_WIDTH  read data.
- o_rvalid  out  1  o_rdata valid (STD: one-cycle pulse; FWFT: equals ~o_empty).
- o_overflow  out  1  sticky: write attempted while full.
- o_underflow  out  1  sticky: read attempted while empty.

## Operation
- Write accepted iff i_we && !o_full. The word is stored at wr_ptr, and wr_ptr increments modulo 2^ADDR_WIDTH.
- Read accepted iff i_re && !o_empty. rd_ptr increments modulo 2^ADDR_WIDTH.
- Flags are evaluated on the registered state. A write while full is rejected even if a read is accepted in the same cycle.
- A read while empty is rejected even if a write is accepted in the same cycle.
- Simultaneous accepted write and read: count unchanged, both pointers advance.
- Count update: +1 on write only, -1 on read only, otherwise held. No wrap beyond 0 or 2^ADDR_WIDTH.
- o_full, o_afull and o_aempty are combinational from the registered count and the threshold ports. Threshold changes take effect the same cycle.
- o_afull with i_afull_th = 0 is constantly 1. o_aempty with i_aempty_th >= 2^ADDR_WIDTH is constantly 1.
- STD_FIFO:
  - o_empty = (count == 0).
  - The RAM read is registered. o_rdata updates only on an accepted read and holds otherwise.
- FWFT:
  - A one-word output register sits in front of the RAM and is included in o_count.
  - o_empty = ~out_valid. o_rdata always presents the head word.
  - An accepted read pops it. The next RAM word reloads the output register on the same edge if available; otherwise out_valid clears.
- Reset (i_arstn low) clears, asynchronously:
  - pointers and count to 0, out_valid to 0;
  - o_rdata, o_rvalid, o_overflow and o_underflow to 0.
  - Then o_empty = 1, o_full = 0, o_count = 0, o_aempty = 1, o_afull = (i_afull_th == 0).
- RAM contents are not reset. Reset mid-transfer discards all stored data.
- i_clr_err clears both error flags on the next edge. A new error in the same cycle as i_clr_err wins, and the flag stays 1.

## Timing
- STD:
  - Write at edge N: o_count and o_empty update after edge N. The word is readable with i_re in cycle N+1.
  - Accepted read sampled at edge M: o_rdata valid and o_rvalid = 1 after edge M, for one cycle. Latency is 1.
- FWFT:
  - Write into an empty FIFO at edge N: the output register loads at edge N+1, and o_empty falls after edge N+1.
  - o_count rises after edge N. Continuous pops at one per cycle are sustained with no bubble.
- Error flags set after the edge that samples the offending request.
- Full-throughput: one write and one read per cycle at any fill level except the boundary rejections above.

## Configuration
- SYNC_FIFO_PF_ERR_FLAGS_EN defined: o_overflow, o_underflow and the i_clr_err logic are implemented as specified.
- Not defined: o_overflow and o_underflow are tied 0, i_clr_err is ignored, and no error registers are synthesised. All other behaviour is identical.

## Test plan
Configuration for all scenarios: DATA_WIDTH = 8, ADDR_WIDTH = 4 (depth 16), SYNC_FIFO_PF_ERR_FLAGS_EN defined unless stated otherwise.

1. STD, reset, write 0x01..0x10 in 16 cycles:
   - o_full = 1 and o_count = 16 after the 16th edge.
   - A 17th write sets o_overflow = 1, and o_count stays 16.
2. STD, drain 16 reads back-to-back:
   - o_rdata = 0x01..0x10 in order, each 1 cycle after its i_re, with o_rvalid pulsing.
   - o_empty = 1 after the last read. A further i_re sets o_underflow = 1, and o_rdata holds 0x10.
3. FWFT, single write 0xA5 into an empty FIFO:
   - o_empty falls 2 edges after i_we, with o_rdata = 0xA5 and o_count = 1.
   - A pop returns the FIFO to o_empty = 1, o_count = 0.
4. Either mode, fill to 8, then simultaneous write/read for 40 cycles across pointer wrap:
   - o_count stays 8, and the data order is preserved.
5. Thresholds i_afull_th = 12, i_aempty_th = 3, filling from 0:
   - o_aempty drops when count goes 3 -> 4.
   - o_afull rises when count goes 11 -> 12.
   - Changing i_afull_th to 8 at count 10 asserts o_afull the same cycle.
6. Assert i_arstn low mid-burst at count 7:
   - All outputs take their reset values immediately.
   - Error flags set before reset are cleared, and i_clr_err clears a pending overflow.
   - With the macro undefined, scenario 1 leaves o_overflow = 0.
